// File: rtl/controle_banco.sv
// Four-state sequencer that reads two operands from a register bank, computes one
// ALU operation and writes the result back, one request every four cycles.
module controle_banco #(
  parameter int unsigned LARGURA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valido,
  output logic               req_pronto,
  input  logic [2:0]         op,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  output logic [4:0]         origem1,
  output logic [4:0]         origem2,
  input  logic [LARGURA-1:0] dado1,
  input  logic [LARGURA-1:0] dado2,
  output logic [4:0]         destino,
  output logic               escrita,
  output logic [LARGURA-1:0] dado_entrada,
  output logic               concluido,
  output logic [LARGURA-1:0] resultado
);

  typedef enum logic [1:0] {StOcioso, StLeitura, StExecucao, StEscrita} estado_e;

  estado_e            estado_q;
  logic [2:0]         op_q;
  logic [4:0]         rs_q, rt_q, rd_q;
  logic [LARGURA-1:0] a_q, b_q, resultado_q, alu_d;
  logic               pronto_q, escrita_q, concluido_q;

  always_comb begin
    alu_d = '0;
    case (op_q)
      3'b000: alu_d = a_q + b_q;
      3'b001: alu_d = a_q - b_q;
      3'b010: alu_d = a_q & b_q;
      3'b011: alu_d = a_q | b_q;
      3'b100: alu_d = a_q ^ b_q;
      3'b101: alu_d = {{(LARGURA-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b110: alu_d = {{(LARGURA-1){1'b0}}, (a_q < b_q)};
      3'b111: alu_d = a_q << b_q[4:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= StOcioso;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resultado_q <= '0;
      pronto_q    <= 1'b1;
      escrita_q   <= 1'b0;
      concluido_q <= 1'b0;
    end else begin
      unique case (estado_q)
        StOcioso: begin
          if (req_valido) begin
            op_q     <= op;
            rs_q     <= rs;
            rt_q     <= rt;
            rd_q     <= rd;
            pronto_q <= 1'b0;
            estado_q <= StLeitura;
          end
        end
        StLeitura: begin
          a_q      <= dado1;
          b_q      <= dado2;
          estado_q <= StExecucao;
        end
        StExecucao: begin
          resultado_q <= alu_d;
          concluido_q <= 1'b1;
          // Writes to r0 are suppressed but still report completion.
          escrita_q   <= (rd_q != 5'd0);
          estado_q    <= StEscrita;
        end
        StEscrita: begin
          concluido_q <= 1'b0;
          escrita_q   <= 1'b0;
          pronto_q    <= 1'b1;
          estado_q    <= StOcioso;
        end
        default: estado_q <= StOcioso;
      endcase
    end
  end

  assign req_pronto   = pronto_q;
  assign origem1      = rs_q;
  assign origem2      = rt_q;
  assign destino      = rd_q;
  assign escrita      = escrita_q;
  assign concluido    = concluido_q;
  assign resultado    = resultado_q;
  assign dado_entrada = resultado_q;

endmodule
